// File: rtl/half_adder_pkg.sv
// Shared constants, types and helpers for the half_adder_pipe leaf adder.
package half_adder_pkg;

    localparam int unsigned HA_MAX_WIDTH = 64;

    // Upper bound used for the saturating statistics counter.
    typedef logic [HA_MAX_WIDTH-1:0] ha_sat_lim_t;

    function automatic int unsigned ha_cnt_w(input int unsigned width);
        int unsigned w;
        w = $clog2(width + 1);
        return (w < 1) ? 1 : w;
    endfunction

    function automatic ha_sat_lim_t ha_sat_lim(input int unsigned cnt_w);
        ha_sat_lim_t lim;
        lim = '0;
        for (int unsigned i = 0; i < cnt_w && i < HA_MAX_WIDTH; i++) begin
            lim[i] = 1'b1;
        end
        return lim;
    endfunction

endpackage

// File: rtl/half_adder_bit.sv
// Single combinational half-adder lane: s = a ^ b, c = a & b.
module half_adder_bit (
    input  logic a,
    input  logic b,
    output logic s,
    output logic c
);

    assign s = a ^ b;
    assign c = a & b;

endmodule

// File: rtl/half_adder_pipe.sv
// WIDTH-lane half adder with combinational and registered outputs plus carry popcount.
// Optional carry-event statistics counter enabled by defining HALF_ADDER_STATS_EN.
module half_adder_pipe
    import half_adder_pkg::*;
#(
    parameter int unsigned WIDTH = 1,
    parameter int unsigned CNT_W = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [WIDTH-1:0]            a,
    input  logic [WIDTH-1:0]            b,
    input  logic                        in_valid,
    output logic [WIDTH-1:0]            s,
    output logic [WIDTH-1:0]            c,
    output logic [WIDTH-1:0]            s_q,
    output logic [WIDTH-1:0]            c_q,
    output logic [ha_cnt_w(WIDTH)-1:0]  c_cnt_q,
    output logic                        out_valid
`ifdef HALF_ADDER_STATS_EN
    ,
    output logic [CNT_W-1:0]            stat_cnt
`endif
);

    localparam int unsigned CW = ha_cnt_w(WIDTH);

    if (WIDTH < 1 || WIDTH > HA_MAX_WIDTH) begin : g_bad_width
        $error("half_adder_pipe: WIDTH out of range 1..%0d", HA_MAX_WIDTH);
    end
    if (CNT_W < 1 || CNT_W > HA_MAX_WIDTH) begin : g_bad_cnt_w
        $error("half_adder_pipe: CNT_W out of range 1..%0d", HA_MAX_WIDTH);
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_lane
        half_adder_bit u_bit (
            .a (a[i]),
            .b (b[i]),
            .s (s[i]),
            .c (c[i])
        );
    end

    logic [CW-1:0] c_cnt;

    always_comb begin
        c_cnt = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            c_cnt = c_cnt + CW'(c[i]);
        end
    end

    // Registered data only loads on capture so X on idle inputs never reaches state.
    always_ff @(posedge clk) begin
        if (rst) begin
            s_q       <= '0;
            c_q       <= '0;
            c_cnt_q   <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                s_q     <= s;
                c_q     <= c;
                c_cnt_q <= c_cnt;
            end
        end
    end

`ifdef HALF_ADDER_STATS_EN
    localparam ha_sat_lim_t STAT_MAX = ha_sat_lim(CNT_W);

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_cnt <= '0;
        end else if (in_valid && (c != '0) && (stat_cnt != STAT_MAX[CNT_W-1:0])) begin
            stat_cnt <= stat_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_half_adder_pipe.sv
// Directed self-checking bench for half_adder_pipe (WIDTH=1 and WIDTH=8 instances).
module tb_half_adder_pipe;

    logic       clk = 1'b0;
    logic       rst;
    logic [0:0] a1, b1;
    logic [0:0] s1, c1, s_q1, c_q1, cnt_q1;
    logic       ov1;
    logic [7:0] a8, b8, s8, c8, s_q8, c_q8;
    logic [3:0] cnt_q8;
    logic       in_valid1, in_valid8, ov8;
`ifdef HALF_ADDER_STATS_EN
    logic [15:0] stat1;
    logic [1:0]  stat8;
`endif

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    half_adder_pipe #(.WIDTH(1), .CNT_W(16)) u_w1 (
        .clk(clk), .rst(rst), .a(a1), .b(b1), .in_valid(in_valid1),
        .s(s1), .c(c1), .s_q(s_q1), .c_q(c_q1), .c_cnt_q(cnt_q1), .out_valid(ov1)
`ifdef HALF_ADDER_STATS_EN
        , .stat_cnt(stat1)
`endif
    );

    half_adder_pipe #(.WIDTH(8), .CNT_W(2)) u_w8 (
        .clk(clk), .rst(rst), .a(a8), .b(b8), .in_valid(in_valid8),
        .s(s8), .c(c8), .s_q(s_q8), .c_q(c_q8), .c_cnt_q(cnt_q8), .out_valid(ov8)
`ifdef HALF_ADDER_STATS_EN
        , .stat_cnt(stat8)
`endif
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [1:0] ab_vec [4]  = '{2'b00, 2'b01, 2'b10, 2'b11};
    logic [1:0] sc_exp [4]  = '{2'b00, 2'b10, 2'b10, 2'b01};

    initial begin
        rst = 1'b1; in_valid1 = 1'b0; in_valid8 = 1'b0;
        a1 = '0; b1 = '0; a8 = '0; b8 = '0;

        // WIDTH=1 truth table, purely combinational
        for (int i = 0; i < 4; i++) begin
            {a1, b1} = ab_vec[i];
            #5;
            check($sformatf("w1_sc_%0d", i), 64'({s1, c1}), 64'(sc_exp[i]));
        end

        tick(); tick();
        check("rst_s_q", 64'(s_q8), 64'h0);
        check("rst_c_q", 64'(c_q8), 64'h0);
        check("rst_cnt", 64'(cnt_q8), 64'h0);
        check("rst_ov", 64'(ov8), 64'h0);
        check("rst_ov_w1", 64'(ov1), 64'h0);
        rst = 1'b0;

        // Single capture
        a8 = 8'hF0; b8 = 8'h3C; in_valid8 = 1'b1;
        #1;
        check("cap_s", 64'(s8), 64'hCC);
        check("cap_c", 64'(c8), 64'h30);
        tick();
        check("cap_s_q", 64'(s_q8), 64'hCC);
        check("cap_c_q", 64'(c_q8), 64'h30);
        check("cap_cnt", 64'(cnt_q8), 64'd2);
        check("cap_ov", 64'(ov8), 64'h1);
        in_valid8 = 1'b0; a8 = 8'hxx; b8 = 8'hxx;
        tick();
        check("hold_ov", 64'(ov8), 64'h0);
        check("hold_s_q", 64'(s_q8), 64'hCC);
        check("hold_c_q", 64'(c_q8), 64'h30);
        check("hold_cnt", 64'(cnt_q8), 64'd2);

        // Back-to-back captures
        a8 = 8'hFF; b8 = 8'hFF; in_valid8 = 1'b1;
        tick();
        check("b2b0_cnt", 64'(cnt_q8), 64'd8);
        check("b2b0_s_q", 64'(s_q8), 64'h00);
        check("b2b0_c_q", 64'(c_q8), 64'hFF);
        check("b2b0_ov", 64'(ov8), 64'h1);
        a8 = 8'h00; b8 = 8'hFF;
        tick();
        check("b2b1_cnt", 64'(cnt_q8), 64'd0);
        check("b2b1_s_q", 64'(s_q8), 64'hFF);
        check("b2b1_c_q", 64'(c_q8), 64'h00);
        check("b2b1_ov", 64'(ov8), 64'h1);

        // Reset beats capture
        rst = 1'b1; a8 = 8'hFF; b8 = 8'hFF;
        tick();
        check("mrst_s_q", 64'(s_q8), 64'h0);
        check("mrst_c_q", 64'(c_q8), 64'h0);
        check("mrst_cnt", 64'(cnt_q8), 64'h0);
        check("mrst_ov", 64'(ov8), 64'h0);
        check("mrst_c", 64'(c8), 64'hFF);
`ifdef HALF_ADDER_STATS_EN
        check("mrst_stat", 64'(stat8), 64'h0);
        rst = 1'b0; a8 = 8'h01; b8 = 8'h01; in_valid8 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("stat_cap%0d", i), 64'(stat8), (i < 3) ? 64'(i + 1) : 64'd3);
        end
        a8 = 8'h00; b8 = 8'h00;
        tick();
        check("stat_zero_c", 64'(stat8), 64'd3);
        in_valid8 = 1'b0;
        tick();
        check("stat_idle", 64'(stat8), 64'd3);
        rst = 1'b1;
        tick();
        check("stat_rst", 64'(stat8), 64'd0);
`endif
        rst = 1'b0; in_valid8 = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/half_adder_pipe.md
Name: half_adder_pipe

Overview:
- WIDTH independent 1-bit half-adder lanes (sum = a XOR b, carry = a AND b).
- Combinational outputs s/c have zero latency; registered copies with a valid flag feed downstream clocked logic.
- Also produces a registered popcount of carry bits.
- Leaf arithmetic block under alu/adder; building block for full adders and ripple/carry-save structures.

Parameters:
- WIDTH, 1, number of independent lanes (legal range 1..64).
- CNT_W, 16, width of the optional carry-event statistics counter.

Ports:
- clk  input  1  system clock, all registers on rising edge
- rst  input  1  reset, synchronous, active-high
- a  input  WIDTH  operand A, one bit per lane
- b  input  WIDTH  operand B, one bit per lane
- in_valid  input  1  a/b qualify for capture this cycle
- s  output  WIDTH  combinational sum, a XOR b per lane
- c  output  WIDTH  combinational carry, a AND b per lane
- s_q  output  WIDTH  registered sum
- c_q  output  WIDTH  registered carry
- c_cnt_q  output  $clog2(WIDTH+1)  registered count of set bits in carry
- out_valid  output  1  s_q/c_q/c_cnt_q are valid
- stat_cnt  output  CNT_W  carry-event counter (only when STATS_EN is defined)

Behaviour:
- One clock domain (clk); reset is synchronous and active-high (rst).
- s and c are purely combinational from a, b.
  - Independent of clk, rst and in_valid.
  - Valid after propagation delay alone.
  - Lanes never interact; no carry chain.
- Truth table per lane (a b : s c): 0 0 : 0 0; 0 1 : 1 0; 1 0 : 1 0; 1 1 : 0 1.
- Reset (rst=1 at a rising edge): s_q=0, c_q=0, c_cnt_q=0, out_valid=0, stat_cnt=0.
- Reset has priority over capture, including when in_valid=1 in the same cycle.
- Capture: on a rising edge with rst=0 and in_valid=1:
  - s_q <= a^b, c_q <= a&b.
  - c_cnt_q <= popcount(a&b).
  - out_valid <= 1.
- Latency is 1 cycle from in_valid to out_valid.
- No capture: on a rising edge with rst=0 and in_valid=0:
  - out_valid <= 0.
  - s_q, c_q, c_cnt_q hold their previous values.
- No backpressure; every valid input is accepted. Back-to-back valids give back-to-back results at full throughput.
- c_cnt_q range is 0..WIDTH. Its width holds WIDTH exactly (WIDTH=1 gives a 1-bit count).
- X on a/b with in_valid=0 must not affect registered state.

Optional Feature:
- Macro: HALF_ADDER_STATS_EN.
- Defined:
  - stat_cnt port exists.
  - On each capture edge where (a&b)!=0, stat_cnt increments by 1.
  - Saturates at 2^CNT_W-1; no wrap.
  - Cleared by rst.
- Undefined: stat_cnt port and its counter are absent; all other behaviour is identical.

Decomposition:
- Package half_adder_pkg:
  - constant HA_MAX_WIDTH=64;
  - function ha_cnt_w(width) returning $clog2(width+1) with minimum 1;
  - typedef of the saturating counter limit.
- Sub-module half_adder_bit:
  - single-lane combinational s=a^b, c=a&b;
  - instantiated WIDTH times via generate.
- Top level holds the registers, popcount and the optional statistics counter.

Test Plan:
- WIDTH=1: apply all four a/b combinations, check s/c 5 ns after each change -> 00:00, 01:10, 10:10, 11:01; no clock needed.
- WIDTH=8: a=0xF0, b=0x3C, in_valid=1 for one cycle -> s=0xCC, c=0x30 immediately; next cycle s_q=0xCC, c_q=0x30, c_cnt_q=2, out_valid=1; following cycle out_valid=0 with s_q/c_q held.
- WIDTH=8: a=b=0xFF, then a=0x00/b=0xFF, back-to-back valids -> c_cnt_q=8 then 0; s_q=0x00 then 0xFF; out_valid high both cycles.
- Reset mid-operation: rst=1 with in_valid=1, a=b=0xFF -> after the edge s_q=c_q=0, c_cnt_q=0, out_valid=0; combinational c still reads 0xFF.
- HALF_ADDER_STATS_EN, CNT_W=2: five captures with a=b=0x01, then one with a=b=0 -> stat_cnt goes 1, 2, 3, 3, 3 and stays 3; rst -> 0.
